// File: rtl/daq_out_buffer.sv
// Frame-level elastic buffer between the ALCT DAQ readout formatter and the DMB link.
// Whole frames are committed to RAM before replay; a frame that does not fit is dropped entirely.
module daq_out_buffer #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic        clk,
    input  logic        hard_rst,
    input  logic [18:0] daq_in,
    output logic [17:0] dout,
    output logic        dout_valid,
    output logic        dout_last,
    input  logic        dout_ready,
    output logic [7:0]  frames_stored,
    output logic [7:0]  frames_dropped,
    output logic        overflow,
    input  logic        ovf_clr
);

    localparam int unsigned     DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CAP       = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [18:0]     IDLE_WORD = {1'b1, 18'h0};

    typedef enum logic [1:0] {
        StWaitIdle,
        StIdle,
        StRecv,
        StDrop
    } state_e;

    state_e          r_state;
    logic [18:0]     r_d1;
    logic [ADDR_W:0] r_wp;
    logic [ADDR_W:0] r_wc;
    logic [ADDR_W:0] r_rp;
    logic [ADDR_W:0] r_rf;
    logic [7:0]      r_dropped;
    logic            r_overflow;
    logic [7:0]      r_stored;

    logic [18:0]     r_mem [DEPTH];
    logic [18:0]     r_ram_q;
    logic            r_ram_v;
    logic [17:0]     r_dout;
    logic            r_dout_valid;
    logic            r_dout_last;

    logic            w_full;
    logic            w_wr_en;
    logic            w_commit;
    logic            w_drop_done;
    logic            w_xfer;
    logic            w_last_xfer;
    logic            w_load;
    logic            w_issue;

    // Occupancy is measured against rp, so words still in the read pipeline stay reserved.
    assign w_full      = (r_wp - r_rp) == CAP;
    assign w_wr_en     = (r_state == StRecv) && !w_full;
    assign w_commit    = w_wr_en && daq_in[18];
    assign w_drop_done = (r_state == StDrop) && r_d1[18];

    assign w_xfer      = r_dout_valid && dout_ready;
    assign w_last_xfer = w_xfer && r_dout_last;
    assign w_load      = r_ram_v && (!r_dout_valid || dout_ready);
    assign w_issue     = (r_rf != r_wc) && (!r_ram_v || w_load);

    assign dout           = r_dout;
    assign dout_valid     = r_dout_valid;
    assign dout_last      = r_dout_last;
    assign frames_stored  = r_stored;
    assign frames_dropped = r_dropped;
    assign overflow       = r_overflow;

    // Frame RAM: one write port, one registered read port with enable.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wp[ADDR_W-1:0]] <= {daq_in[18], r_d1[17:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_ram_q <= r_mem[r_rf[ADDR_W-1:0]];
        end
    end

    // Write-side frame FSM.
    always_ff @(posedge clk or negedge hard_rst) begin
        if (!hard_rst) begin
            r_state <= StWaitIdle;
            r_d1    <= IDLE_WORD;
            r_wp    <= '0;
            r_wc    <= '0;
        end else begin
            r_d1 <= daq_in;
            case (r_state)
                StWaitIdle: begin
                    if (daq_in[18]) begin
                        r_state <= StIdle;
                    end
                end
                StIdle: begin
                    if (!daq_in[18]) begin
                        r_state <= StRecv;
                    end
                end
                StRecv: begin
                    if (w_full) begin
                        r_wp    <= r_wc;
                        r_state <= StDrop;
                    end else begin
                        r_wp <= r_wp + PTR_ONE;
                        if (daq_in[18]) begin
                            r_wc    <= r_wp + PTR_ONE;
                            r_state <= StIdle;
                        end
                    end
                end
                StDrop: begin
                    // A frame may start right behind the terminating idle; do not miss it.
                    if (r_d1[18]) begin
                        r_state <= daq_in[18] ? StIdle : StRecv;
                    end
                end
                default: r_state <= StWaitIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge hard_rst) begin
        if (!hard_rst) begin
            r_dropped  <= 8'd0;
            r_overflow <= 1'b0;
        end else if (ovf_clr) begin
            r_dropped  <= 8'd0;
            r_overflow <= 1'b0;
        end else if (w_drop_done) begin
            r_overflow <= 1'b1;
            if (r_dropped != 8'hFF) begin
                r_dropped <= r_dropped + 8'd1;
            end
        end
    end

    // Read side: RAM read register feeding a show-ahead output register.
    always_ff @(posedge clk or negedge hard_rst) begin
        if (!hard_rst) begin
            r_rf         <= '0;
            r_rp         <= '0;
            r_ram_v      <= 1'b0;
            r_dout       <= 18'h0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
        end else begin
            if (w_issue) begin
                r_rf <= r_rf + PTR_ONE;
            end
            if (w_xfer) begin
                r_rp <= r_rp + PTR_ONE;
            end
            if (w_issue) begin
                r_ram_v <= 1'b1;
            end else if (w_load) begin
                r_ram_v <= 1'b0;
            end
            if (w_load) begin
                r_dout       <= r_ram_q[17:0];
                r_dout_last  <= r_ram_q[18];
                r_dout_valid <= 1'b1;
            end else if (w_xfer) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge hard_rst) begin
        if (!hard_rst) begin
            r_stored <= 8'd0;
        end else if (w_commit && !w_last_xfer) begin
            r_stored <= r_stored + 8'd1;
        end else if (!w_commit && w_last_xfer) begin
            r_stored <= r_stored - 8'd1;
        end
    end

endmodule

// File: tb/tb_daq_out_buffer.sv
// Bench for daq_out_buffer: a 1024-word and a 16-word instance share one stimulus stream;
// a frame-order scoreboard plus directed checks on latency, drops, saturation and reset.
module tb_daq_out_buffer;

    localparam logic [18:0] IDLE = 19'h40000;

    logic        clk        = 1'b0;
    logic        hard_rst   = 1'b0;
    logic [18:0] daq_in     = IDLE;
    logic        dout_ready = 1'b0;
    logic        ovf_clr    = 1'b0;

    logic [17:0] dout           [2];
    logic        dout_valid     [2];
    logic        dout_last      [2];
    logic [7:0]  frames_stored  [2];
    logic [7:0]  frames_dropped [2];
    logic        overflow       [2];

    always #12 clk = ~clk;

    // Instance 0: ADDR_W = 10 (1023 words). Instance 1: ADDR_W = 4 (15 words).
    for (genvar g = 0; g < 2; g++) begin : g_dut
        daq_out_buffer #(.ADDR_W(g == 0 ? 10 : 4)) u_dut (
            .clk            (clk),
            .hard_rst       (hard_rst),
            .daq_in         (daq_in),
            .dout           (dout[g]),
            .dout_valid     (dout_valid[g]),
            .dout_last      (dout_last[g]),
            .dout_ready     (dout_ready),
            .frames_stored  (frames_stored[g]),
            .frames_dropped (frames_dropped[g]),
            .overflow       (overflow[g]),
            .ovf_clr        (ovf_clr)
        );
    end

    int n_err = 0;
    int n_chk = 0;
    bit rnd_ready = 1'b0;

    // Every frame ever offered, flattened; each instance must emit an in-order subset of whole frames.
    logic [17:0] sent_w   [$];
    int          sent_st  [$];
    int          sent_len [$];
    logic [17:0] fw       [$];

    int          sb_fi   [2];
    int          sb_wi   [2];
    int          sb_skip [2];
    logic [17:0] sb_ew;
    logic        sb_el;

    typedef struct {
        int len;
        int st_s;
        int dr_s;
        int ov_s;
        int st_b;
    } drop_vec_t;

    drop_vec_t   tbl [4];
    int          cnt;
    logic [31:0] lmask;

    initial begin
        for (int g = 0; g < 2; g++) begin
            sb_fi[g]   = 0;
            sb_wi[g]   = 0;
            sb_skip[g] = 0;
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (hard_rst && dout_valid[g] && dout_ready) begin
                if (sb_wi[g] == 0) begin
                    while (sb_fi[g] < sent_len.size() && sent_w[sent_st[sb_fi[g]]] != dout[g]) begin
                        sb_fi[g]++;
                        sb_skip[g]++;
                    end
                end
                n_chk++;
                if (sb_fi[g] >= sent_len.size()) begin
                    n_err++;
                    $display("FAIL sb_unexpected[%0d]: got word %05h, required no word (no frame pending)",
                             g, dout[g]);
                end else begin
                    sb_ew = sent_w[sent_st[sb_fi[g]] + sb_wi[g]];
                    sb_el = (sb_wi[g] == sent_len[sb_fi[g]] - 1);
                    if (dout[g] !== sb_ew || dout_last[g] !== sb_el) begin
                        n_err++;
                        $display("FAIL sb_word[%0d] frame %0d word %0d: got %05h last=%0b, required %05h last=%0b",
                                 g, sb_fi[g], sb_wi[g], dout[g], dout_last[g], sb_ew, sb_el);
                    end
                    if (sb_el) begin
                        sb_wi[g] = 0;
                        sb_fi[g]++;
                    end else begin
                        sb_wi[g]++;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) dout_ready = ($urandom_range(3) != 0);
    endtask

    task automatic fw_rand(input int n);
        fw.delete();
        repeat (n) fw.push_back(18'($urandom));
    endtask

    task automatic fw_count(input logic [17:0] base, input int n);
        fw.delete();
        for (int i = 0; i < n; i++) fw.push_back(base + 18'(i));
    endtask

    // Drives fw word by word and leaves daq_in idle right after the last sampling edge.
    task automatic drive_fw();
        sent_st.push_back(sent_w.size());
        sent_len.push_back(fw.size());
        foreach (fw[i]) sent_w.push_back(fw[i]);
        foreach (fw[i]) begin
            daq_in = {1'b0, fw[i]};
            tick();
        end
        daq_in = IDLE;
    endtask

    task automatic send_fw();
        drive_fw();
        tick();
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!dout_valid[0] && !dout_valid[1] && frames_stored[0] == 8'd0 &&
                frames_stored[1] == 8'd0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        n_chk++;
        if (!done) begin
            n_err++;
            $display("FAIL %s: buffers still busy, required empty within 3000 cycles", name);
        end
    endtask

    task automatic do_reset(input string name);
        hard_rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            sb_fi[g] = sent_len.size();
            sb_wi[g] = 0;
        end
        tick();
        tick();
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s_data%0d", name, g), 32'({dout[g], dout_valid[g], dout_last[g]}), 32'h0);
            chk($sformatf("%s_stat%0d", name, g),
                32'({frames_stored[g], frames_dropped[g], overflow[g]}), 32'h0);
        end
        hard_rst = 1'b1;
        tick();
    endtask

    task automatic pulse_clr();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
    endtask

    initial begin
        tbl[0] = '{10, 1, 0, 0, 1};
        tbl[1] = '{10, 1, 1, 1, 2};
        tbl[2] = '{5,  2, 1, 1, 3};
        tbl[3] = '{1,  2, 2, 1, 4};

        do_reset("reset");
        repeat (3) tick();

        // 25-word frame, first-word latency, then drain.
        dout_ready = 1'b1;
        fw.delete();
        fw.push_back(18'h0DB0A);
        for (int i = 1; i <= 23; i++) fw.push_back(18'(i));
        fw.push_back(18'h1D000);
        drive_fw();
        tick();
        tick();
        @(negedge clk);
        chk("lat_early_valid", 32'(dout_valid[0]), 32'h0);
        tick();
        @(negedge clk);
        chk("lat_valid", 32'(dout_valid[0]), 32'h1);
        chk("lat_first_word", 32'(dout[0]), 32'h0DB0A);
        chk("lat_stored", 32'(frames_stored[0]), 32'h1);
        drain("drain_25");
        @(negedge clk);
        chk("f25_stored_after", 32'(frames_stored[0]), 32'h0);
        chk("f25_small_dropped", 32'({frames_dropped[1], overflow[1]}), 32'h003);
        pulse_clr();
        @(negedge clk);
        chk("clr_small", 32'({frames_dropped[1], overflow[1]}), 32'h0);

        // Frames of 5, 1 and 7 words held back, then released.
        dout_ready = 1'b0;
        fw_count(18'h01000, 5);
        send_fw();
        fw_count(18'h02000, 1);
        send_fw();
        fw_count(18'h03000, 7);
        send_fw();
        repeat (5) tick();
        @(negedge clk);
        chk("three_stored_big", 32'(frames_stored[0]), 32'd3);
        chk("three_stored_small", 32'(frames_stored[1]), 32'd3);
        chk("hold_first_word", 32'({dout_valid[0], dout[0]}), {13'h0, 1'b1, 18'h01000});
        tick();
        dout_ready = 1'b1;
        cnt = 0;
        lmask = 32'h0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dout_valid[0]) begin
                if (dout_last[0] && cnt < 32) lmask[cnt] = 1'b1;
                cnt++;
            end
        end
        chk("seq_words", 32'(cnt), 32'd13);
        chk("seq_lastmask", lmask, 32'h1030);
        drain("drain_three");
        chk("three_stored_after", 32'(frames_stored[0]), 32'h0);

        // Drop table on the 15-word instance, reads stalled.
        do_reset("reset_drop");
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fw_count(18'h04000 + 18'(i) * 18'h01000, tbl[i].len);
            send_fw();
            tick();
            @(negedge clk);
            chk($sformatf("drop%0d_stored_s", i), 32'(frames_stored[1]), 32'(tbl[i].st_s));
            chk($sformatf("drop%0d_dropped_s", i), 32'(frames_dropped[1]), 32'(tbl[i].dr_s));
            chk($sformatf("drop%0d_ovf_s", i), 32'(overflow[1]), 32'(tbl[i].ov_s));
            chk($sformatf("drop%0d_stored_b", i), 32'(frames_stored[0]), 32'(tbl[i].st_b));
        end
        dout_ready = 1'b1;
        drain("drain_drop");

        // Address wrap: 40 seven-word frames with continuous reads.
        pulse_clr();
        for (int i = 0; i < 40; i++) begin
            fw_rand(7);
            send_fw();
        end
        drain("drain_wrap");
        @(negedge clk);
        chk("wrap_no_drop", 32'({frames_dropped[1], overflow[1]}), 32'h0);
        chk("wrap_all_frames", 32'(sb_fi[1]), 32'(sent_len.size()));

        // Saturation of frames_dropped.
        dout_ready = 1'b0;
        fw_rand(15);
        send_fw();
        for (int i = 0; i < 254; i++) begin
            fw_rand(1);
            send_fw();
        end
        tick();
        @(negedge clk);
        chk("sat_254", 32'(frames_dropped[1]), 32'd254);
        for (int i = 0; i < 2; i++) begin
            fw_rand(1);
            send_fw();
        end
        tick();
        @(negedge clk);
        chk("sat_255", 32'({frames_dropped[1], overflow[1]}), 32'h1FF);
        dout_ready = 1'b1;
        drain("drain_sat");
        pulse_clr();
        @(negedge clk);
        chk("clr_sat", 32'({frames_dropped[1], overflow[1]}), 32'h0);

        // ovf_clr coinciding with a completing drop.
        dout_ready = 1'b0;
        fw_rand(15);
        send_fw();
        fw_rand(1);
        send_fw();
        tick();
        @(negedge clk);
        chk("drop_one", 32'({frames_dropped[1], overflow[1]}), 32'h3);
        fw_rand(1);
        drive_fw();
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("clr_wins", 32'({frames_dropped[1], overflow[1]}), 32'h0);
        fw_rand(1);
        send_fw();
        tick();
        @(negedge clk);
        chk("drop_after_clr", 32'({frames_dropped[1], overflow[1]}), 32'h3);
        dout_ready = 1'b1;
        drain("drain_clr");

        // Reset asserted and released mid-frame.
        daq_in = {1'b0, 18'($urandom)};
        repeat (3) tick();
        do_reset("reset_mid");
        for (int i = 0; i < 4; i++) begin
            daq_in = {1'b0, 18'($urandom)};
            tick();
        end
        daq_in = IDLE;
        tick();
        tick();
        fw_rand(6);
        send_fw();
        drain("drain_rst");
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rst_frame_seen%0d", g), 32'(sb_fi[g]), 32'(sent_len.size()));
        end

        // Randomized traffic with random back-pressure.
        pulse_clr();
        for (int g = 0; g < 2; g++) sb_skip[g] = 0;
        rnd_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            fw_rand($urandom_range(1, 12));
            drive_fw();
            repeat ($urandom_range(1, 6)) tick();
        end
        rnd_ready = 1'b0;
        dout_ready = 1'b1;
        drain("drain_rand");
        fw_rand(2);
        send_fw();
        drain("drain_final");
        @(negedge clk);
        chk("rand_big_all", 32'(sb_fi[0]), 32'(sent_len.size()));
        chk("rand_small_all", 32'(sb_fi[1]), 32'(sent_len.size()));
        chk("rand_big_skips", 32'(sb_skip[0]), 32'h0);
        chk("rand_big_dropped", 32'(frames_dropped[0]), 32'h0);
        chk("rand_small_dropped", 32'(frames_dropped[1]), 32'(sb_skip[1]));
        chk("rand_align", 32'(sb_wi[0] + sb_wi[1]), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
